// File: rtl/pattern_sequencer.sv
// Purpose : writable DEPTH-slot character table replayed on a valid/ready stream, forward or reverse, loop or one-shot.
// Latency : first character one cycle after start; one character per cycle while o_out_valid & i_out_ready.
// Backpressure: pointer and o_out_char hold while i_out_ready is low; nothing is dropped.
//
// Ports:
//   i_clk, i_rst_n                 rising-edge clock, synchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data    table write port (honoured in IDLE only, out-of-range addresses dropped)
//   i_len, i_mode, i_dir           message length (clamped 1..DEPTH), 0=loop/1=one-shot, 0=forward/1=reverse
//   i_start, i_stop                start (level, IDLE only) and abort (wins over start and handshake)
//   o_out_valid/i_out_ready/o_out_char   character stream
//   o_pos_onehot, o_busy, o_done   current slot, RUN indicator, end-of-one-shot pulse
module pattern_sequencer #(
    parameter int DEPTH  = 5,
    parameter int CHAR_W = 7,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [CHAR_W-1:0] i_wr_data,
    input  logic [AW:0]       i_len,
    input  logic              i_mode,
    input  logic              i_dir,
    input  logic              i_start,
    input  logic              i_stop,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CHAR_W-1:0] o_out_char,
    output logic [DEPTH-1:0]  o_pos_onehot,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [CHAR_W-1:0] r_table [DEPTH];
    state_t            r_state;
    logic [AW-1:0]     r_pos;
    logic [AW:0]       r_len;
    logic              r_mode;
    logic              r_dir;
    logic              r_out_valid;
    logic [CHAR_W-1:0] r_out_char;
    logic [DEPTH-1:0]  r_pos_onehot;
    logic              r_busy;
    logic              r_done;

    logic [AW:0]       w_len_clamp;
    logic [AW-1:0]     w_start_pos;
    logic [AW-1:0]     w_end_idx;
    logic              w_last;
    logic [AW-1:0]     w_next_pos;
    logic              w_wr_ok;
    logic              w_hs;

    // Clamp applied to the raw length so the latched L is always 1..DEPTH.
    assign w_len_clamp = (i_len == '0)     ? (AW+1)'(1) :
                         (i_len > DEPTH_L) ? DEPTH_L    : i_len;
    assign w_start_pos = i_dir ? AW'(w_len_clamp - (AW+1)'(1)) : '0;

    // Final slot of the running message depends on direction.
    assign w_end_idx  = AW'(r_len - (AW+1)'(1));
    assign w_last     = r_dir ? (r_pos == '0) : (r_pos == w_end_idx);
    assign w_next_pos = w_last ? (r_dir ? w_end_idx : '0)
                               : (r_dir ? r_pos - AW'(1) : r_pos + AW'(1));

    assign w_wr_ok = ({1'b0, i_wr_addr} < DEPTH_L);
    assign w_hs    = r_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
            r_state      <= S_IDLE;
            r_pos        <= '0;
            r_len        <= (AW+1)'(1);
            r_mode       <= 1'b0;
            r_dir        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_char   <= '0;
            r_pos_onehot <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_wr_en && w_wr_ok) r_table[i_wr_addr] <= i_wr_data;
                    if (i_start && !i_stop) begin
                        r_state      <= S_RUN;
                        r_len        <= w_len_clamp;
                        r_mode       <= i_mode;
                        r_dir        <= i_dir;
                        r_pos        <= w_start_pos;
                        r_out_valid  <= 1'b1;
                        r_out_char   <= r_table[w_start_pos];
                        r_pos_onehot <= DEPTH'(1) << w_start_pos;
                        r_busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Stop wins: the current character may be consumed, but nothing advances.
                    if (i_stop || (w_hs && w_last && r_mode)) begin
                        r_state      <= S_IDLE;
                        r_pos        <= '0;
                        r_out_valid  <= 1'b0;
                        r_out_char   <= '0;
                        r_pos_onehot <= '0;
                        r_busy       <= 1'b0;
                        r_done       <= !i_stop;
                    end else if (w_hs) begin
                        r_pos        <= w_next_pos;
                        r_out_char   <= r_table[w_next_pos];
                        r_pos_onehot <= DEPTH'(1) << w_next_pos;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_char   = r_out_char;
    assign o_pos_onehot = r_pos_onehot;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Purpose : directed self-checking bench for pattern_sequencer (DEPTH=5, CHAR_W=7).
// Latency : inputs driven and outputs sampled on the falling edge, one cycle per step.
// Backpressure: i_out_ready driven directly by each scenario.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic [3:0] len = '0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [6:0] out_char;
    logic [4:0] pos_onehot;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    logic [6:0] msg [5];

    always #5 clk = ~clk;

    pattern_sequencer #(.DEPTH(5), .CHAR_W(7)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_len(len), .i_mode(mode), .i_dir(dir),
        .i_start(start), .i_stop(stop),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_char(out_char),
        .o_pos_onehot(pos_onehot), .o_busy(busy), .o_done(done)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [6:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] l, input logic m, input logic d);
        len = l; mode = m; dir = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stop_run;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({out_valid, out_char, pos_onehot, busy, done} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b c=%h oh=%b busy=%b done=%b exp all zero",
                     out_valid, out_char, pos_onehot, busy, done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_loop_fwd;
        out_ready = 1'b1;
        start_run(4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_char !== msg[i % 5] || pos_onehot !== 5'(1 << (i % 5)) || !out_valid || !busy) begin
                failures++;
                $display("FAIL loop_fwd[%0d] got c=%h oh=%b v=%b b=%b exp c=%h oh=%b v=1 b=1",
                         i, out_char, pos_onehot, out_valid, busy, msg[i % 5], 5'(1 << (i % 5)));
            end
        end
        stop_run();
    endtask

    task automatic test_oneshot_rev;
        out_ready = 1'b1;
        start_run(4'd5, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_char !== msg[4 - i] || pos_onehot !== 5'(1 << (4 - i)) || done) begin
                failures++;
                $display("FAIL oneshot_rev[%0d] got c=%h oh=%b done=%b exp c=%h oh=%b done=0",
                         i, out_char, pos_onehot, done, msg[4 - i], 5'(1 << (4 - i)));
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || pos_onehot !== 5'b0) begin
            failures++;
            $display("FAIL oneshot_end got done=%b busy=%b v=%b oh=%b exp done=1 busy=0 v=0 oh=0",
                     done, busy, out_valid, pos_onehot);
        end
        tick();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_done_pulse got done=%b v=%b exp done=0 v=0", done, out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        start_run(4'd5, 1'b0, 1'b0);
        tick(); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_char !== 7'h63 || pos_onehot !== 5'b00100 || !out_valid) begin
                failures++;
                $display("FAIL backpressure_hold[%0d] got c=%h oh=%b v=%b exp c=63 oh=00100 v=1",
                         i, out_char, pos_onehot, out_valid);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_char !== 7'h6F || pos_onehot !== 5'b01000) begin
            failures++;
            $display("FAIL backpressure_release got c=%h oh=%b exp c=6f oh=01000", out_char, pos_onehot);
        end
        stop_run();
    endtask

    task automatic test_len_clamp;
        out_ready = 1'b1;
        start_run(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_char !== 7'h4A || pos_onehot !== 5'b00001 || !out_valid) begin
                failures++;
                $display("FAIL len0[%0d] got c=%h oh=%b v=%b exp c=4a oh=00001 v=1",
                         i, out_char, pos_onehot, out_valid);
            end
        end
        stop_run();
        start_run(4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_char !== msg[i % 5] || pos_onehot !== 5'(1 << (i % 5))) begin
                failures++;
                $display("FAIL len7[%0d] got c=%h oh=%b exp c=%h oh=%b",
                         i, out_char, pos_onehot, msg[i % 5], 5'(1 << (i % 5)));
            end
        end
        stop_run();
        // Reverse with an over-long length must start from slot DEPTH-1.
        start_run(4'd9, 1'b0, 1'b1);
        checks++;
        if (out_char !== 7'h62 || pos_onehot !== 5'b10000) begin
            failures++;
            $display("FAIL len9_rev_start got c=%h oh=%b exp c=62 oh=10000", out_char, pos_onehot);
        end
        stop_run();
    endtask

    task automatic test_blocked_writes;
        out_ready = 1'b0;
        start_run(4'd5, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 7'h11;
        tick();
        wr_en = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_char !== 7'h61) begin
            failures++;
            $display("FAIL write_in_run got c=%h exp c=61", out_char);
        end
        stop_run();
        write_slot(3'd5, 7'h7F);
        write_slot(3'd7, 7'h7E);
        start_run(4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_char !== msg[i]) begin
                failures++;
                $display("FAIL oob_write[%0d] got c=%h exp c=%h", i, out_char, msg[i]);
            end
        end
        stop_run();
    endtask

    task automatic test_stop_handshake;
        out_ready = 1'b1;
        start_run(4'd5, 1'b1, 1'b0);
        tick(); tick(); tick();
        checks++;
        if (out_char !== 7'h6F) begin
            failures++;
            $display("FAIL stop_setup got c=%h exp c=6f", out_char);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pos_onehot !== 5'b0) begin
            failures++;
            $display("FAIL stop_with_hs got v=%b busy=%b done=%b oh=%b exp all 0",
                     out_valid, busy, done, pos_onehot);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stop_beats_start got busy=%b v=%b exp 0 0", busy, out_valid);
        end
        start_run(4'd5, 1'b0, 1'b0);
        checks++;
        if (out_char !== 7'h4A || pos_onehot !== 5'b00001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart got c=%h oh=%b busy=%b exp c=4a oh=00001 busy=1",
                     out_char, pos_onehot, busy);
        end
        stop_run();
    endtask

    task automatic test_reset_mid_run;
        out_ready = 1'b1;
        start_run(4'd5, 1'b1, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_char, pos_onehot, busy, done} !== 15'h0) begin
            failures++;
            $display("FAIL reset_mid_run got v=%b c=%h oh=%b busy=%b done=%b exp all zero",
                     out_valid, out_char, pos_onehot, busy, done);
        end
        rst_n = 1'b1;
        tick();
        start_run(4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_char !== 7'h00 || pos_onehot !== 5'(1 << i) || !out_valid) begin
                failures++;
                $display("FAIL cleared_table[%0d] got c=%h oh=%b v=%b exp c=00 oh=%b v=1",
                         i, out_char, pos_onehot, out_valid, 5'(1 << i));
            end
        end
        stop_run();
    endtask

    initial begin
        msg[0] = 7'h4A; msg[1] = 7'h61; msg[2] = 7'h63; msg[3] = 7'h6F; msg[4] = 7'h62;
        @(negedge clk);
        test_reset();
        for (int i = 0; i < 5; i++) write_slot(3'(i), msg[i]);
        test_loop_fwd();
        test_oneshot_rev();
        test_backpressure();
        test_len_clamp();
        test_blocked_writes();
        test_stop_handshake();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Parametrised successor to the fixed five-slot ring counter and ASCII encoder. It holds a writable table of DEPTH characters and steps a one-hot position pointer through the first `len` slots, forward or reverse, in loop or one-shot mode. Each character is presented on a valid/ready stream, so the pointer advances only when the consumer accepts. The block sits between configuration logic, which loads the message, and a character sink such as a display driver or UART TX.

## Interface
- DEPTH, 5: number of character slots (≥1).
- CHAR_W, 7: character width in bits.
- AW, max(1, clog2(DEPTH)): slot-index width (derived).

- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  reset, synchronous, active-low.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  slot index to write.
- wr_data  in  CHAR_W  character to write.
- len  in  AW+1  active message length, sampled on start.
- mode  in  1  0 = loop, 1 = one-shot; sampled on start.
- dir  in  1  0 = forward (slot 0 up), 1 = reverse (slot L-1 down); sampled on start.
- start  in  1  begin sequencing; level, acted on in IDLE only.
- stop  in  1  abort sequencing.
- out_valid  out  1  out_char is valid.
- out_ready  in  1  consumer accepts.
- out_char  out  CHAR_W  current character.
- pos_onehot  out  DEPTH  one-hot current slot; zero in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of a one-shot message.

## Operation
- Reset (RST=0 at an edge): state=IDLE, all table slots=0, pos=0, out_valid=0, out_char=0, pos_onehot=0, busy=0, done=0, latched L/mode/dir=1/0/0.
- Table writes take effect only in IDLE. wr_en is ignored in RUN, and writes with wr_addr ≥ DEPTH are dropped.
- Length clamp at start: L = 1 if len=0; DEPTH if len>DEPTH; otherwise len.
- States:
  - IDLE: on start=1 and stop=0, latch L, mode and dir, then go to RUN. The start position is 0 for forward and L-1 for reverse.
  - RUN: out_valid=1, out_char=table[pos], pos_onehot=1<<pos, busy=1.
    - Handshake: out_valid & out_ready.
    - On handshake at a non-final slot: pos moves to pos+1 (forward) or pos-1 (reverse).
    - On handshake at the final slot (L-1 forward, 0 reverse):
      - Loop mode: wrap to 0 (forward) or L-1 (reverse) and stay in RUN.
      - One-shot mode: go to IDLE and pulse done.
    - stop=1: go to IDLE with no done pulse, whether or not a handshake occurs that cycle.
- Simultaneous events:
  - stop beats handshake. The character is consumed, but pos is not advanced and done is not pulsed.
  - stop beats start in IDLE, so the block stays IDLE.
  - start in RUN is ignored.
  - L=1 in loop mode re-presents slot 0 after every handshake.
- All outputs are registered. out_char and pos_onehot stay stable while out_valid=1 and out_ready=0.

## Timing
- start sampled at edge t: out_valid=1 with the first character visible after edge t (cycle t+1).
- Handshake at edge t: the next character or the wrapped character is visible in cycle t+1. Throughput is one character per cycle with out_ready held at 1.
- Final one-shot handshake at edge t: in cycle t+1, done=1, busy=0, out_valid=0, pos_onehot=0. done returns to 0 at edge t+1.
- stop sampled at edge t: IDLE in cycle t+1.
- A table write at edge t is readable by a start issued at edge t+1 or later.
- Reset sampled mid-RUN: IDLE with the table cleared in the next cycle. No done pulse, no further out_valid.

## Test plan
- Reset, then write "J","a","c","o","b" (0x4A,0x61,0x63,0x6F,0x62) to slots 0–4. Start with len=5, mode=0, dir=0, out_ready=1 → out_char sequence 4A,61,63,6F,62,4A,61…; pos_onehot 00001,00010,00100,01000,10000,00001.
- Same table, mode=1, dir=1 → 62,6F,63,61,4A, then done=1 for exactly one cycle, busy=0, pos_onehot=0.
- Backpressure: hold out_ready=0 for 3 cycles on slot 2 → out_char stays 0x63 and pos_onehot stays 00100. Raise out_ready → 0x6F the next cycle.
- Length clamp:
  - len=0 in loop mode → 0x4A repeated on every handshake.
  - len=7 → behaves as L=5.
- Illegal and blocked writes:
  - wr_en during RUN to slot 1 → no effect; 0x61 still appears.
  - wr_addr=5 while IDLE → no table change.
- Abort cases:
  - stop asserted together with a handshake on slot 3 (0x6F) → IDLE next cycle, done=0.
  - Restart → message begins again at 0x4A.
  - RST=0 mid-RUN → all outputs 0, and a restart emits 0x00 characters because the table is cleared.
